// File: rtl/mem_responder_pkg.sv
// Shared types for the main-memory responder.
// Word lanes are little-endian: lane 0 is the byte at addr+0.
package mem_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [0:3] word_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } mem_state_t;

  localparam int BYTES_PER_WORD = 4;

  function automatic logic [31:0] pack_word(
    input word_t w
  );
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      v[8*i +: 8] = w[i];
    return v;
  endfunction

  function automatic word_t unpack_word(
    input logic [31:0] v
  );
    word_t w;
    w = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      w[i] = v[8*i +: 8];
    return w;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the cache fill port and memory.
// MEM_ADDR_CHECK_EN adds the mem_error response flag.
interface mem_responder_if;
  import mem_pkg::*;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  word_t       mem_data_in;
  word_t       mem_data_out;
  logic        mem_ready;
  logic        mem_busy;
`ifdef MEM_ADDR_CHECK_EN
  logic        mem_error;

  modport master (
    output mem_req, mem_addr,
    output mem_write_en, mem_data_in,
    input  mem_data_out, mem_ready,
    input  mem_busy, mem_error
  );

  modport slave (
    input  mem_req, mem_addr,
    input  mem_write_en, mem_data_in,
    output mem_data_out, mem_ready,
    output mem_busy, mem_error
  );
`else
  modport master (
    output mem_req, mem_addr,
    output mem_write_en, mem_data_in,
    input  mem_data_out, mem_ready,
    input  mem_busy
  );

  modport slave (
    input  mem_req, mem_addr,
    input  mem_write_en, mem_data_in,
    output mem_data_out, mem_ready,
    output mem_busy
  );
`endif

endinterface

// File: rtl/mem_responder_array.sv
// Word storage: synchronous write, registered read,
// whole array cleared by asynchronous reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  word_t         wdata,
  output word_t         rdata
);

  localparam int DEPTH = 1 << AW;

  word_t mem_q [DEPTH];
  word_t rdata_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we)
        mem_q[idx] <= wdata;
      if (re)
        rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory end of the cache fill/write-back port with fixed latency.
// MEM_ADDR_CHECK_EN flags unaligned/out-of-range requests.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WORD_ADDR_BITS = 10,
  parameter int LATENCY        = 4
) (
  input  logic      clk,
  input  logic      rst_b,
  mem_responder_if.slave bus
);

  localparam int IW = WORD_ADDR_BITS;

  mem_state_t    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          we_q, we_d;
  word_t         wdata_q, wdata_d;
  logic          bad_q, bad_d;
  logic          access;
  logic          bad_in;
  logic          arr_we, arr_re;
  word_t         rdata;

`ifdef MEM_ADDR_CHECK_EN
  assign bad_in = (bus.mem_addr[1:0] != 2'b00)
                | (|bus.mem_addr[31:IW+2]);
`else
  logic unused_addr;
  assign unused_addr = ^{bus.mem_addr[31:IW+2],
                         bus.mem_addr[1:0]};
  assign bad_in = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    bad_d   = bad_q;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          state_d = BUSY;
          cnt_d   = 4'(LATENCY - 1);
          idx_d   = bus.mem_addr[IW+1:2];
          we_d    = bus.mem_write_en;
          wdata_d = bus.mem_data_in;
          bad_d   = bad_in;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      bad_q   <= bad_d;
    end
  end

  // Flagged requests never touch the array.
  assign arr_we = access & we_q & ~bad_q;
  assign arr_re = access & ~we_q & ~bad_q;

  mem_array #(
    .AW (IW)
  ) u_array (
    .clk   (clk),
    .rst_b (rst_b),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  assign bus.mem_ready = (state_q == RESP);
  assign bus.mem_busy  = (state_q != IDLE);

`ifdef MEM_ADDR_CHECK_EN
  // A flagged read shows zero until the next good read.
  logic zero_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      zero_q <= 1'b0;
    else if (access & ~we_q)
      zero_q <= bad_q;
  end

  assign bus.mem_data_out = zero_q ? '0 : rdata;
  assign bus.mem_error    = (state_q == RESP) & bad_q;
`else
  assign bus.mem_data_out = rdata;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder against a
// word-array reference model.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int LAT = 4;
  localparam int AW  = 10;
  localparam int NW  = 1 << AW;

  logic clk   = 1'b0;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  mem_responder_if bus ();
  mem_responder_if bus1 ();

  mem_responder #(
    .WORD_ADDR_BITS (AW),
    .LATENCY        (LAT)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  mem_responder #(
    .WORD_ADDR_BITS (AW),
    .LATENCY        (1)
  ) dut1 (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus1)
  );

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] ref_mem [NW];
  logic [31:0] last_rd;

  task automatic model_clear();
    for (int i = 0; i < NW; i++)
      ref_mem[i] = 32'h0;
    last_rd = 32'h0;
  endtask

  // One request on dut; expectations come from the word model.
  task automatic access(
    input logic [31:0] addr,
    input logic        we,
    input logic [31:0] wd,
    input string       tag
  );
    bit          bad;
    int          idx;
    int          k;
    bit          busy_ok;
    logic [31:0] got;
    bad = 1'b0;
`ifdef MEM_ADDR_CHECK_EN
    bad = (addr % 4 != 0) || (addr >= 32'd4096);
`endif
    idx = int'((addr / 4) % NW);
    if (we) begin
      if (!bad)
        ref_mem[idx] = wd;
    end else begin
      last_rd = bad ? 32'h0 : ref_mem[idx];
    end
    bus.mem_req      = 1'b1;
    bus.mem_addr     = addr;
    bus.mem_write_en = we;
    bus.mem_data_in  = unpack_word(wd);
    @(posedge clk);
    #1;
    bus.mem_req      = 1'b0;
    bus.mem_addr     = $urandom;
    bus.mem_write_en = 1'($urandom_range(0, 1));
    bus.mem_data_in  = unpack_word($urandom);
    busy_ok = 1'b1;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (bus.mem_ready === 1'b1)
        break;
      if (bus.mem_busy !== 1'b1)
        busy_ok = 1'b0;
    end
    ntests++;
    if (k != LAT + 1) begin
      nfail++;
      $display("FAIL %s latency: got %0d want %0d",
               tag, k, LAT + 1);
    end
    ntests++;
    if (!busy_ok || bus.mem_busy !== 1'b1) begin
      nfail++;
      $display("FAIL %s busy: busy_ok=%0d busy=%b want 1",
               tag, busy_ok, bus.mem_busy);
    end
    got = pack_word(bus.mem_data_out);
    ntests++;
    if (got !== last_rd) begin
      nfail++;
      $display("FAIL %s data: got %h want %h",
               tag, got, last_rd);
    end
`ifdef MEM_ADDR_CHECK_EN
    ntests++;
    if (bus.mem_error !== bad) begin
      nfail++;
      $display("FAIL %s error: got %b want %b",
               tag, bus.mem_error, bad);
    end
`endif
    @(negedge clk);
    ntests++;
    if (bus.mem_ready !== 1'b0 || bus.mem_busy !== 1'b0) begin
      nfail++;
      $display("FAIL %s pulse: ready=%b busy=%b want 0 0",
               tag, bus.mem_ready, bus.mem_busy);
    end
  endtask

  task automatic test_reset();
    #1 rst_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ntests++;
    if (bus.mem_ready !== 1'b0 || bus.mem_busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_hs: ready=%b busy=%b want 0 0",
               bus.mem_ready, bus.mem_busy);
    end
    ntests++;
    if (pack_word(bus.mem_data_out) !== 32'h0) begin
      nfail++;
      $display("FAIL reset_data: got %h want 0",
               pack_word(bus.mem_data_out));
    end
`ifdef MEM_ADDR_CHECK_EN
    ntests++;
    if (bus.mem_error !== 1'b0) begin
      nfail++;
      $display("FAIL reset_err: got %b want 0", bus.mem_error);
    end
`endif
    model_clear();
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_after_reset();
    access(32'h0000_0010, 1'b0, 32'h0, "rd_reset");
  endtask

  task automatic test_write_read();
    access(32'h0000_0040, 1'b1, 32'hDEAD_BEEF, "wr_40");
    access(32'h0000_0040, 1'b0, 32'h0, "rd_40");
    ntests++;
    if (bus.mem_data_out[0] !== 8'hEF ||
        bus.mem_data_out[3] !== 8'hDE) begin
      nfail++;
      $display("FAIL lanes: lane0=%h lane3=%h want EF DE",
               bus.mem_data_out[0], bus.mem_data_out[3]);
    end
  endtask

  task automatic test_wrap();
    access(32'h0000_1004, 1'b1, 32'hCAFE_F00D, "wr_wrap");
    access(32'h0000_0004, 1'b0, 32'h0, "rd_wrap");
  endtask

  task automatic test_unaligned();
    access(32'h0000_0042, 1'b0, 32'h0, "rd_unal");
    access(32'h0000_0040, 1'b0, 32'h0, "rd_al");
  endtask

  task automatic test_reset_mid_busy();
    int seen;
    bus.mem_req      = 1'b1;
    bus.mem_addr     = 32'h0000_000C;
    bus.mem_write_en = 1'b1;
    bus.mem_data_in  = unpack_word(32'h1122_3344);
    @(posedge clk);
    #1 bus.mem_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    ntests++;
    if (bus.mem_busy !== 1'b0 || bus.mem_ready !== 1'b0) begin
      nfail++;
      $display("FAIL abort: busy=%b ready=%b want 0 0",
               bus.mem_busy, bus.mem_ready);
    end
    @(negedge clk);
    rst_b = 1'b1;
    model_clear();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.mem_ready === 1'b1)
        seen++;
    end
    ntests++;
    if (seen != 0) begin
      nfail++;
      $display("FAIL abort_ready: got %0d pulses want 0", seen);
    end
    access(32'h0000_000C, 1'b0, 32'h0, "rd_abort");
  endtask

  // LATENCY=1 instance: held mem_req gives one pulse per 3 cycles.
  task automatic test_back_to_back();
    int  pulses;
    bit  want;
    bus1.mem_req      = 1'b1;
    bus1.mem_addr     = 32'h0000_0014;
    bus1.mem_write_en = 1'b1;
    bus1.mem_data_in  = unpack_word(32'hA5A5_0001);
    @(posedge clk);
    #1 bus1.mem_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ntests++;
    if (bus1.mem_ready !== 1'b1) begin
      nfail++;
      $display("FAIL b2b_wr: ready=%b want 1", bus1.mem_ready);
    end
    @(negedge clk);
    bus1.mem_req      = 1'b1;
    bus1.mem_write_en = 1'b0;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      bus1.mem_addr = ((n + 1) % 3 == 1) ? 32'h14 : 32'h20;
      @(negedge clk);
      want = (n + 1 >= 2) && ((n + 1 - 2) % 3 == 0);
      if (bus1.mem_ready === 1'b1)
        pulses++;
      ntests++;
      if (bus1.mem_ready !== want) begin
        nfail++;
        $display("FAIL b2b_cyc%0d: ready=%b want %b",
                 n + 1, bus1.mem_ready, want);
      end
    end
    bus1.mem_req = 1'b0;
    ntests++;
    if (pulses != 7) begin
      nfail++;
      $display("FAIL b2b_count: got %0d want 7", pulses);
    end
    ntests++;
    if (pack_word(bus1.mem_data_out) !== 32'hA5A5_0001) begin
      nfail++;
      $display("FAIL b2b_data: got %h want a5a50001",
               pack_word(bus1.mem_data_out));
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        w;
    for (int i = 0; i < 30; i++) begin
      a = 32'($urandom_range(0, 7)) << 2;
      if ($urandom_range(0, 3) == 0)
        a = a | 32'h0000_1000;
      if ($urandom_range(0, 3) == 0)
        a = a | 32'($urandom_range(1, 3));
      w = 1'($urandom_range(0, 1));
      access(a, w, $urandom, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    bus.mem_req       = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_write_en  = 1'b0;
    bus.mem_data_in   = '0;
    bus1.mem_req      = 1'b0;
    bus1.mem_addr     = '0;
    bus1.mem_write_en = 1'b0;
    bus1.mem_data_in  = '0;
    model_clear();
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_wrap();
    test_unaligned();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
